// File: rtl/router_sync_param_if.sv
// Bundle between the packet FSM / output FIFOs and the router synchroniser.
// The FSM/FIFO side uses the master modport; the synchroniser uses the slave modport.
interface router_sync_param_if #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] data_in;
   logic              detect_add;
   logic              write_enb_reg;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] read_enb;
   logic [NUM_CH-1:0] timeout_en;
   logic [NUM_CH-1:0] write_enb;
   logic              fifo_full;
   logic [NUM_CH-1:0] vld_out;
   logic [NUM_CH-1:0] soft_reset;
   logic              addr_err;

   modport master (
      output data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
      input  write_enb, fifo_full, vld_out, soft_reset, addr_err
   );

   modport slave (
      input  data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
      output write_enb, fifo_full, vld_out, soft_reset, addr_err
   );
endinterface

// File: rtl/router_sync_param.sv
// Router synchroniser: latches the header address, steers writes to one FIFO,
// returns that FIFO's full flag, and runs a per-channel stalled-read watchdog.
module router_sync_param #(
   parameter int NUM_CH    = 3,
   parameter int ADDR_W    = 2,
   parameter int TIMEOUT   = 30,
   parameter int CNT_W     = 5,
   parameter bit MASK_FULL = 1'b0
) (
   input logic               clock,
   input logic               resetn,
   router_sync_param_if.slave bus
);
   logic [ADDR_W-1:0] addr_q;
   logic              addr_err_reg;
   logic [NUM_CH-1:0] addr_sel;
   logic [NUM_CH-1:0] data_sel;
   logic [NUM_CH-1:0] soft_reset_vec;
   logic              addr_vld;
   logic              data_vld;
   logic              sel_full;
   logic              write_ok;

   // Decode by equality rather than indexing so out-of-range addresses simply select nothing.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
         assign addr_sel[gi] = (addr_q == ADDR_W'(gi));
         assign data_sel[gi] = (bus.data_in == ADDR_W'(gi));
      end
   endgenerate

   assign addr_vld = |addr_sel;
   assign data_vld = |data_sel;
   assign sel_full = |(addr_sel & bus.full);
   assign write_ok = bus.write_enb_reg && addr_vld && !(MASK_FULL && sel_full);

   assign bus.fifo_full  = sel_full;
   assign bus.write_enb  = write_ok ? addr_sel : '0;
   assign bus.vld_out    = ~bus.empty;
   assign bus.addr_err   = addr_err_reg;
   assign bus.soft_reset = soft_reset_vec;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         addr_q       <= '0;
         addr_err_reg <= 1'b0;
      end else if (bus.detect_add) begin
         addr_q       <= bus.data_in;
         addr_err_reg <= !data_vld;
      end else begin
         addr_err_reg <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_wdog
         logic [CNT_W-1:0] cnt_reg;
         logic             pulse_reg;
         logic             stall;

         assign stall = ~bus.empty[gi] & ~bus.read_enb[gi] & bus.timeout_en[gi];

         // Wrapping to 0 on the pulse makes a continued stall fire again TIMEOUT cycles later.
         always_ff @(posedge clock) begin
            if (!resetn || !stall) begin
               cnt_reg   <= '0;
               pulse_reg <= 1'b0;
            end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               cnt_reg   <= '0;
               pulse_reg <= 1'b1;
            end else begin
               cnt_reg   <= cnt_reg + CNT_W'(1);
               pulse_reg <= 1'b0;
            end
         end

         assign soft_reset_vec[gi] = pulse_reg;
      end
   endgenerate
endmodule

// File: tb/tb_router_sync_param.sv
// Bench for router_sync_param: directed scenarios plus random traffic, with plain and
// MASK_FULL instances driven in parallel and compared against a behavioural model.
module tb_router_sync_param;
   localparam int NUM_CH  = 3;
   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 30;
   localparam int CNT_W   = 5;

   logic clock = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   router_sync_param_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus0 ();
   router_sync_param_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus1 ();

   assign bus1.data_in       = bus0.data_in;
   assign bus1.detect_add    = bus0.detect_add;
   assign bus1.write_enb_reg = bus0.write_enb_reg;
   assign bus1.full          = bus0.full;
   assign bus1.empty         = bus0.empty;
   assign bus1.read_enb      = bus0.read_enb;
   assign bus1.timeout_en    = bus0.timeout_en;

   router_sync_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
                       .MASK_FULL(1'b0)) dut_plain (.clock(clock), .resetn(resetn), .bus(bus0));
   router_sync_param #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
                       .MASK_FULL(1'b1)) dut_mask (.clock(clock), .resetn(resetn), .bus(bus1));

   always #5 clock = ~clock;

   // Model: latched address, and per channel the length of the current unbroken stall run.
   int              m_addr;
   bit              m_err;
   bit [NUM_CH-1:0] m_sr;
   int              m_run [NUM_CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %0h expected %0h", tag, step_no, got, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0;
      m_err  = 1'b0;
      m_sr   = '0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
   endtask

   task automatic set_idle();
      bus0.data_in       = '0;
      bus0.detect_add    = 1'b0;
      bus0.write_enb_reg = 1'b0;
      bus0.full          = '0;
      bus0.empty         = '1;
      bus0.read_enb      = '0;
      bus0.timeout_en    = '0;
   endtask

   // One clock: check combinational outputs, apply the edge to the model, check registers.
   task automatic step();
      logic [NUM_CH-1:0] exp_we, exp_we_m, exp_vld;
      bit ok, ff, stall;
      #1;
      ok       = (m_addr < NUM_CH);
      ff       = ok ? bus0.full[m_addr] : 1'b0;
      exp_we   = (bus0.write_enb_reg && ok) ? (NUM_CH'(1) << m_addr) : '0;
      exp_we_m = ff ? '0 : exp_we;
      exp_vld  = ~bus0.empty;
      check("write_enb", bus0.write_enb, exp_we);
      check("write_enb_mask", bus1.write_enb, exp_we_m);
      check("fifo_full", bus0.fifo_full, ff);
      check("fifo_full_mask", bus1.fifo_full, ff);
      check("vld_out", bus0.vld_out, exp_vld);
      @(posedge clock);
      if (!resetn) begin
         model_reset();
      end else begin
         if (bus0.detect_add) begin
            m_addr = int'(bus0.data_in);
            m_err  = (m_addr >= NUM_CH);
         end else begin
            m_err = 1'b0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            stall = !bus0.empty[i] && !bus0.read_enb[i] && bus0.timeout_en[i];
            if (stall) begin
               m_run[i]++;
               m_sr[i] = ((m_run[i] % TIMEOUT) == 0);
            end else begin
               m_run[i] = 0;
               m_sr[i]  = 1'b0;
            end
         end
      end
      @(negedge clock);
      step_no++;
      check("soft_reset", bus0.soft_reset, m_sr);
      check("soft_reset_mask", bus1.soft_reset, m_sr);
      check("addr_err", bus0.addr_err, m_err);
   endtask

   initial begin
      int first, cnt;
      logic [NUM_CH-1:0] first_val;
      logic [NUM_CH-1:0] seg_empty;

      set_idle();
      resetn = 1'b0;
      @(posedge clock);
      @(negedge clock);
      model_reset();
      step();
      check("reset_soft_reset", bus0.soft_reset, 0);
      check("reset_addr_err", bus0.addr_err, 0);
      $display("scenario reset done checks=%0d", checks);

      // Header to channel 2, then a write and the full flag of that channel.
      resetn = 1'b1;
      bus0.detect_add = 1'b1;
      bus0.data_in    = 2'd2;
      step();
      bus0.detect_add    = 1'b0;
      bus0.write_enb_reg = 1'b1;
      #1;
      check("s1_write_enb", bus0.write_enb, 3'b100);
      check("s1_fifo_full_low", bus0.fifo_full, 0);
      step();
      bus0.full = 3'b100;
      #1;
      check("s1_fifo_full", bus0.fifo_full, 1);
      step();
      $display("scenario header_write done checks=%0d", checks);

      // Plain stall on channel 0.
      set_idle();
      step();
      bus0.empty      = 3'b110;
      bus0.timeout_en = 3'b001;
      first = -1;
      cnt   = 0;
      for (int k = 1; k <= 32; k++) begin
         step();
         if (bus0.soft_reset[0]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      check("s2_pulse_step", first, 30);
      check("s2_pulse_count", cnt, 1);
      $display("scenario stall_timeout done checks=%0d", checks);

      // Stall broken by one read at cycle 29.
      set_idle();
      step();
      bus0.empty      = 3'b110;
      bus0.timeout_en = 3'b001;
      first = -1;
      cnt   = 0;
      for (int k = 1; k <= 65; k++) begin
         bus0.read_enb = (k == 29) ? 3'b001 : 3'b000;
         step();
         if (bus0.soft_reset[0]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      check("s3_pulse_step", first, 59);
      check("s3_pulse_count", cnt, 1);
      $display("scenario read_restart done checks=%0d", checks);

      // Out-of-range address.
      set_idle();
      bus0.detect_add = 1'b1;
      bus0.data_in    = 2'd3;
      step();
      check("s4_addr_err", bus0.addr_err, 1);
      bus0.detect_add    = 1'b0;
      bus0.write_enb_reg = 1'b1;
      bus0.full          = '1;
      #1;
      check("s4_write_enb", bus0.write_enb, 0);
      check("s4_fifo_full", bus0.fifo_full, 0);
      step();
      check("s4_addr_err_clear", bus0.addr_err, 0);
      $display("scenario bad_addr done checks=%0d", checks);

      // Full masking on channel 1.
      set_idle();
      bus0.detect_add = 1'b1;
      bus0.data_in    = 2'd1;
      step();
      bus0.detect_add    = 1'b0;
      bus0.write_enb_reg = 1'b1;
      bus0.full          = 3'b010;
      #1;
      check("s5_mask_blocked", bus1.write_enb, 0);
      check("s5_plain_writes", bus0.write_enb, 3'b010);
      step();
      bus0.full = 3'b000;
      #1;
      check("s5_mask_open", bus1.write_enb, 3'b010);
      step();
      $display("scenario mask_full done checks=%0d", checks);

      // Two channels stalled, reset mid-count.
      set_idle();
      step();
      bus0.empty      = 3'b010;
      bus0.timeout_en = 3'b101;
      for (int k = 1; k <= 14; k++) step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      first     = -1;
      first_val = '0;
      for (int k = 1; k <= 35; k++) begin
         step();
         if (bus0.soft_reset != '0 && first < 0) begin
            first     = k;
            first_val = bus0.soft_reset;
         end
      end
      check("s6_pulse_step", first, 30);
      check("s6_pulse_chans", first_val, 3'b101);
      $display("scenario reset_mid_stall done checks=%0d", checks);

      // Random traffic in segments with long stalls.
      set_idle();
      seg_empty = '1;
      for (int k = 0; k < 3000; k++) begin
         if ((k % 64) == 0) begin
            seg_empty       = NUM_CH'($urandom_range(0, 7));
            bus0.timeout_en = NUM_CH'($urandom_range(0, 7));
         end
         for (int i = 0; i < NUM_CH; i++) begin
            bus0.read_enb[i] = ($urandom_range(0, 31) == 0);
            bus0.empty[i]    = seg_empty[i] ^ ($urandom_range(0, 49) == 0);
         end
         resetn             = ($urandom_range(0, 199) != 0);
         bus0.detect_add    = ($urandom_range(0, 3) == 0);
         bus0.data_in       = ADDR_W'($urandom_range(0, 3));
         bus0.write_enb_reg = ($urandom_range(0, 1) == 1);
         bus0.full          = NUM_CH'($urandom_range(0, 7));
         step();
      end
      resetn = 1'b1;
      $display("scenario random done checks=%0d", checks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
